// File: rtl/matrix_frame_sched.sv
// Round-robin frame scheduler for an 8x8 serial LED strip: grants one source per frame,
// fetches one pixel bit per LED and shifts out start frame, colour words and end frame.
module matrix_frame_sched #(
    parameter int NUM_LEDS  = 64,
    parameter int FRAME_DIV = 5000,
    parameter int SNAKE     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  req,
    input  logic [63:0] fg_colour,
    input  logic [63:0] bg_colour,
    output logic [5:0]  pix_addr,
    output logic        pix_rd,
    input  logic [1:0]  pix_bit,
    output logic [1:0]  gnt,
    output logic [1:0]  frame_done,
    output logic        busy,
    output logic        led_clk,
    output logic        led_data
);

    localparam int             TW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(FRAME_DIV - 1);
    localparam logic [6:0]     LAST_N    = 7'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_FETCH = 3'd3,
        S_LED   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t         r_state;
    logic [TW-1:0]  r_tick_cnt;
    logic           r_tick_pending;
    logic           r_rr;
    logic [6:0]     r_cnt;
    logic [6:0]     r_n;
    logic [31:0]    r_shift;
    logic [1:0]     r_gnt;
    logic [1:0]     r_frame_done;
    logic           r_busy;
    logic           r_pix_rd;
    logic [5:0]     r_pix_addr;
    logic           r_led_clk;
    logic           r_led_data;

    logic           w_win;
    logic           w_src;
    logic [31:0]    w_word;
    logic [6:0]     w_n_next;
    logic           w_tick_wrap;
    logic           w_frame_start;

    // Odd rows run right-to-left on a snaked strip; 7-col is the bitwise inverse of col.
    function automatic logic [5:0] map_addr(input logic [5:0] n);
        if ((SNAKE != 32'sd0) && n[3]) begin
            map_addr = {n[5:3], ~n[2:0]};
        end else begin
            map_addr = n;
        end
    endfunction

    assign w_n_next      = r_n + 7'd1;
    assign w_tick_wrap   = (r_tick_cnt == TICK_LAST);
    assign w_frame_start = (r_state == S_IDLE) && en && r_tick_pending && (|req);

    // Arbitration winner and colour word selected by the captured pixel bit
    always_comb begin
        w_win  = 1'b0;
        w_word = 32'd0;
        w_src  = r_gnt[1];
        case (req)
            2'b11:   w_win = r_rr;
            2'b10:   w_win = 1'b1;
            default: w_win = 1'b0;
        endcase
        if (w_src) begin
            if (pix_bit[1]) begin
                w_word = fg_colour[63:32];
            end else begin
                w_word = bg_colour[63:32];
            end
        end else begin
            if (pix_bit[0]) begin
                w_word = fg_colour[31:0];
            end else begin
                w_word = bg_colour[31:0];
            end
        end
    end

    // Free-running frame-rate divider; a single pending flag absorbs extra ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt     <= '0;
            r_tick_pending <= 1'b0;
        end else begin
            if (w_tick_wrap) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + {{(TW-1){1'b0}}, 1'b1};
            end
            if (w_tick_wrap) begin
                r_tick_pending <= 1'b1;
            end else if (w_frame_start) begin
                r_tick_pending <= 1'b0;
            end
        end
    end

    // Frame sequencer; every output register holds the value for the cycle it is visible in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_rr         <= 1'b0;
            r_cnt        <= 7'd0;
            r_n          <= 7'd0;
            r_shift      <= 32'd0;
            r_gnt        <= 2'b00;
            r_frame_done <= 2'b00;
            r_busy       <= 1'b0;
            r_pix_rd     <= 1'b0;
            r_pix_addr   <= 6'd0;
            r_led_clk    <= 1'b0;
            r_led_data   <= 1'b0;
        end else begin
            r_pix_rd     <= 1'b0;
            r_frame_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    r_gnt      <= 2'b00;
                    r_led_clk  <= 1'b0;
                    r_led_data <= 1'b0;
                    if (w_frame_start) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (req == 2'b00) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gnt      <= w_win ? 2'b10 : 2'b01;
                        r_rr       <= ~w_win;
                        r_n        <= 7'd0;
                        r_cnt      <= 7'd0;
                        r_led_clk  <= 1'b0;
                        r_led_data <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_led_data <= 1'b0;
                    if (r_cnt == 7'd63) begin
                        r_cnt      <= 7'd0;
                        r_led_clk  <= 1'b0;
                        r_pix_rd   <= 1'b1;
                        r_pix_addr <= map_addr(r_n[5:0]);
                        r_state    <= S_FETCH;
                    end else begin
                        r_cnt     <= r_cnt + 7'd1;
                        r_led_clk <= ~r_cnt[0];
                    end
                end
                S_FETCH: begin
                    r_led_clk <= 1'b0;
                    if (r_cnt == 7'd0) begin
                        r_cnt      <= 7'd1;
                        r_led_data <= 1'b0;
                    end else begin
                        // Pixel bit is valid now; MSB goes straight out as LED phase A
                        r_cnt      <= 7'd0;
                        r_led_data <= w_word[31];
                        r_shift    <= {w_word[30:0], 1'b0};
                        r_state    <= S_LED;
                    end
                end
                S_LED: begin
                    if (r_cnt == 7'd63) begin
                        r_cnt      <= 7'd0;
                        r_led_clk  <= 1'b0;
                        r_led_data <= 1'b0;
                        r_n        <= w_n_next;
                        if (r_n == LAST_N) begin
                            r_state <= S_END;
                        end else begin
                            r_pix_rd   <= 1'b1;
                            r_pix_addr <= map_addr(w_n_next[5:0]);
                            r_state    <= S_FETCH;
                        end
                    end else if (r_cnt[0]) begin
                        r_cnt      <= r_cnt + 7'd1;
                        r_led_clk  <= 1'b0;
                        r_led_data <= r_shift[31];
                        r_shift    <= {r_shift[30:0], 1'b0};
                    end else begin
                        r_cnt     <= r_cnt + 7'd1;
                        r_led_clk <= 1'b1;
                    end
                end
                S_END: begin
                    r_led_data <= 1'b0;
                    if (r_cnt == 7'd127) begin
                        r_cnt        <= 7'd0;
                        r_led_clk    <= 1'b0;
                        r_frame_done <= r_gnt;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt     <= r_cnt + 7'd1;
                        r_led_clk <= ~r_cnt[0];
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_gnt      <= 2'b00;
                    r_led_clk  <= 1'b0;
                    r_led_data <= 1'b0;
                end
            endcase
        end
    end

    assign pix_addr   = r_pix_addr;
    assign pix_rd     = r_pix_rd;
    assign gnt        = r_gnt;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign led_clk    = r_led_clk;
    assign led_data   = r_led_data;

endmodule

// File: tb/tb_matrix_frame_sched.sv
// Self-checking bench for matrix_frame_sched: random pixel/colour data compared against a
// frame-level model of the strip stream, grant order and address map.
module tb_matrix_frame_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  req;
    logic [63:0] fg_colour;
    logic [63:0] bg_colour;
    logic [5:0]  pix_addr;
    logic        pix_rd;
    logic [1:0]  pix_bit = 2'b00;
    logic [1:0]  gnt;
    logic [1:0]  frame_done;
    logic        busy;
    logic        led_clk;
    logic        led_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem0, mem1;
    int          model_rr;

    logic        stream[$];
    logic [5:0]  addrs[$];
    int          gnt_cycles;
    logic [1:0]  gnt_or;
    int          fd_count;
    logic [1:0]  fd_or;

    localparam int FRAME_BITS = 32 + 64 * 32 + 64;

    matrix_frame_sched #(.NUM_LEDS(64), .FRAME_DIV(5000), .SNAKE(1)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .fg_colour(fg_colour), .bg_colour(bg_colour),
        .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_bit(pix_bit),
        .gnt(gnt), .frame_done(frame_done), .busy(busy),
        .led_clk(led_clk), .led_data(led_data)
    );

    always #5 clk = ~clk;

    // Pixel sources: registered read, data valid the cycle after pix_rd
    always @(posedge clk) begin
        if (pix_rd) pix_bit <= {mem1[pix_addr], mem0[pix_addr]};
    end

    always @(posedge led_clk) stream.push_back(led_data);

    always @(negedge clk) begin
        if (pix_rd) addrs.push_back(pix_addr);
        if (gnt != 2'b00) begin
            gnt_cycles = gnt_cycles + 1;
            gnt_or     = gnt_or | gnt;
        end
        if (frame_done != 2'b00) begin
            fd_count = fd_count + 1;
            fd_or    = fd_or | frame_done;
        end
    end

    task automatic clear_mon();
        stream.delete();
        addrs.delete();
        gnt_cycles = 0;
        gnt_or     = 2'b00;
        fd_count   = 0;
        fd_or      = 2'b00;
    endtask

    task automatic randomize_sources();
        mem0      = {$urandom, $urandom};
        mem1      = {$urandom, $urandom};
        fg_colour = {$urandom, $urandom};
        bg_colour = {$urandom, $urandom};
    endtask

    function automatic int exp_addr(input int n);
        int row, col;
        row = n / 8;
        col = n % 8;
        if (row % 2 == 1) return row * 8 + 7 - col;
        return n;
    endfunction

    function automatic logic [31:0] exp_word(input int src, input int n);
        int   a;
        logic b;
        a = exp_addr(n);
        if (src == 1) begin
            b = mem1[a];
            return b ? fg_colour[63:32] : bg_colour[63:32];
        end
        b = mem0[a];
        return b ? fg_colour[31:0] : bg_colour[31:0];
    endfunction

    function automatic int stream_errors(input int src);
        int          errs;
        logic [31:0] w;
        logic        eb;
        if (stream.size() != FRAME_BITS) return -1;
        errs = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i < 32 || i >= 32 + 64 * 32) begin
                eb = 1'b0;
            end else begin
                w  = exp_word(src, (i - 32) / 32);
                eb = w[31 - ((i - 32) % 32)];
            end
            if (stream[i] !== eb) errs++;
        end
        return errs;
    endfunction

    function automatic int addr_errors();
        int errs;
        if (addrs.size() != 64) return -1;
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            if (int'(addrs[i]) != exp_addr(i)) errs++;
        end
        return errs;
    endfunction

    function automatic logic [31:0] stream_word(input int idx);
        logic [31:0] w;
        w = 32'hxxxxxxxx;
        if (stream.size() >= 32 + (idx + 1) * 32) begin
            for (int k = 0; k < 32; k++) w[31 - k] = stream[32 + idx * 32 + k];
        end
        return w;
    endfunction

    function automatic int model_grant(input logic [1:0] r);
        if (r == 2'b11) return model_rr;
        if (r[1]) return 1;
        return 0;
    endfunction

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done != 2'b00) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) @(negedge clk);
    endtask

    task automatic wait_addrs(input int count, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (addrs.size() >= count) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle_watch(input int cycles, output int busy_seen);
        busy_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        int          start_cyc;
        bit          to;
        int          e;
        logic [31:0] w;
        int          tail_ones;
        reset = 1'b0; en = 1'b0; req = 2'b00;
        mem0 = 64'h0000_0000_0000_0001; mem1 = {$urandom, $urandom};
        fg_colour = {$urandom, 32'hf0000f00};
        bg_colour = {$urandom, 32'hf0070000};
        repeat (3) @(negedge clk);
        outs = {gnt, frame_done, busy, led_clk, led_data, pix_rd, pix_addr};
        n_tests++;
        if (outs !== 16'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0000", outs); end

        clear_mon();
        model_rr = 0;
        reset = 1'b1; en = 1'b1; req = 2'b01;
        start_cyc = -1;
        for (int i = 1; i <= 6000; i++) begin
            @(negedge clk);
            if (busy) begin start_cyc = i; break; end
        end
        n_tests++;
        if (start_cyc < 4995 || start_cyc > 5010) begin
            n_fail++; $display("FAIL first_frame_start: got cycle %0d expected 4995..5010", start_cyc);
        end
        model_rr = 1 - model_grant(2'b01);
        wait_done(6000, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL first_frame_done_timeout: got timeout expected frame_done"); end
        n_tests++;
        if (fd_or !== 2'b01 || fd_count != 1) begin
            n_fail++; $display("FAIL first_frame_done: got %b x%0d expected 01 x1", fd_or, fd_count);
        end
        n_tests++;
        if (gnt_or !== 2'b01 || gnt_cycles != 4417) begin
            n_fail++; $display("FAIL first_gnt: got %b for %0d clk expected 01 for 4417", gnt_or, gnt_cycles);
        end
        e = stream_errors(0);
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL first_stream: got %0d errors (%0d bits) expected 0", e, stream.size()); end
        w = stream_word(0);
        n_tests++;
        if (w !== 32'hf0000f00) begin n_fail++; $display("FAIL led_word0: got %h expected f0000f00", w); end
        w = stream_word(1);
        n_tests++;
        if (w !== 32'hf0070000) begin n_fail++; $display("FAIL led_word1: got %h expected f0070000", w); end
        tail_ones = 0;
        for (int i = 0; i < 64; i++) begin
            if (stream.size() < FRAME_BITS || stream[FRAME_BITS - 64 + i] !== 1'b0) tail_ones++;
        end
        n_tests++;
        if (tail_ones != 0) begin n_fail++; $display("FAIL end_frame: got %0d bad bits expected 0", tail_ones); end
        e = addr_errors();
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL addr_map: got %0d errors (%0d reads) expected 0", e, addrs.size()); end
        for (int n = 8; n <= 16; n++) begin
            n_tests++;
            if (addrs.size() <= n || int'(addrs[n]) != ((n == 16) ? 16 : 23 - n)) begin
                n_fail++;
                $display("FAIL snake_addr_n%0d: got %0d expected %0d", n,
                         (addrs.size() > n) ? int'(addrs[n]) : -1, (n == 16) ? 16 : 23 - n);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_round_robin();
        bit         to;
        int         w, e, seen;
        logic [1:0] exp;
        randomize_sources();
        req = 2'b11; en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            clear_mon();
            w = model_grant(2'b11);
            model_rr = 1 - w;
            exp = (w == 1) ? 2'b10 : 2'b01;
            if (f == 3) begin
                for (int i = 0; i < 7000 && !busy; i++) @(negedge clk);
                repeat (100) @(negedge clk);
                en = 1'b0;
            end
            wait_done(7000, to);
            n_tests++;
            if (to || fd_or !== exp || fd_count != 1) begin
                n_fail++; $display("FAIL rr_frame_done_%0d: got %b x%0d expected %b x1", f, fd_or, fd_count, exp);
            end
            n_tests++;
            if (gnt_or !== exp || gnt_cycles != 4417) begin
                n_fail++; $display("FAIL rr_gnt_%0d: got %b for %0d clk expected %b for 4417", f, gnt_or, gnt_cycles, exp);
            end
            e = stream_errors(w);
            n_tests++;
            if (e != 0) begin n_fail++; $display("FAIL rr_stream_%0d: got %0d errors expected 0", f, e); end
        end
        idle_watch(6000, seen);
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL en_low_idle: got %0d busy clk expected 0", seen); end
        req = 2'b00;
    endtask

    task automatic test_req_drop();
        bit to;
        int e, seen;
        randomize_sources();
        clear_mon();
        en = 1'b1; req = 2'b01;
        model_rr = 1 - model_grant(2'b01);
        wait_addrs(11, 7000, to);
        req = 2'b00;
        wait_done(7000, to);
        n_tests++;
        if (to || fd_or !== 2'b01) begin n_fail++; $display("FAIL drop_frame_done: got %b expected 01", fd_or); end
        e = stream_errors(0);
        n_tests++;
        if (e != 0) begin n_fail++; $display("FAIL drop_stream: got %0d errors (%0d bits) expected 0", e, stream.size()); end
        idle_watch(6000, seen);
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL drop_no_restart: got %0d busy clk expected 0", seen); end
        clear_mon();
        req = 2'b10;
        model_rr = 1 - model_grant(2'b10);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pending_immediate: got busy=%b expected 1", busy); end
        wait_done(7000, to);
        e = stream_errors(1);
        n_tests++;
        if (to || fd_or !== 2'b10 || e != 0) begin
            n_fail++; $display("FAIL pending_frame: got done=%b errors=%0d expected 10 and 0", fd_or, e);
        end
        req = 2'b00;
    endtask

    task automatic test_reset_midframe();
        bit          to;
        int          e;
        logic [15:0] outs;
        randomize_sources();
        clear_mon();
        en = 1'b1; req = 2'b01;
        wait_addrs(31, 7000, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL midframe_reach: got timeout expected n=30"); end
        reset = 1'b0;
        #1;
        outs = {gnt, frame_done, busy, led_clk, led_data, pix_rd, pix_addr};
        n_tests++;
        if (outs !== 16'd0) begin n_fail++; $display("FAIL midframe_reset_now: got %h expected 0000", outs); end
        repeat (3) @(negedge clk);
        outs = {gnt, frame_done, busy, led_clk, led_data, pix_rd, pix_addr};
        n_tests++;
        if (outs !== 16'd0) begin n_fail++; $display("FAIL midframe_reset_hold: got %h expected 0000", outs); end
        model_rr = 0;
        clear_mon();
        req = 2'b11;
        reset = 1'b1;
        model_rr = 1 - model_grant(2'b11);
        repeat (200) @(negedge clk);
        n_tests++;
        if (fd_count != 0) begin n_fail++; $display("FAIL stale_frame_done: got %0d pulses expected 0", fd_count); end
        wait_done(10000, to);
        n_tests++;
        if (to || fd_count != 1 || fd_or !== 2'b01 || gnt_or !== 2'b01) begin
            n_fail++; $display("FAIL restart_grant: got done=%b x%0d gnt=%b expected 01 x1 gnt=01", fd_or, fd_count, gnt_or);
        end
        e = stream_errors(0);
        n_tests++;
        if (e != 0 || addrs.size() == 0 || addrs[0] !== 6'd0) begin
            n_fail++; $display("FAIL restart_stream: got %0d errors (%0d bits) expected 0", e, stream.size());
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_req_drop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_frame_sched.md
Name: matrix_frame_sched

Overview:
Frame scheduler for the 8x8 serial LED matrix. Two pixel sources share one matrix: requester 0 is the scroll text engine and requester 1 is the status overlay. The block arbitrates between them round-robin, one whole frame per grant. For the granted source it fetches one pixel bit per LED and maps that bit to that source's foreground or background colour word. It serialises the result as a clock/data strip stream: 32-bit zero start frame, one 32-bit word per LED, zero end frame.

Parameters:
NUM_LEDS, 64, LEDs per frame; 8 per row.
FRAME_DIV, 5000, clk cycles between frame-rate ticks. Must be at least the frame length.
SNAKE, 1, when 1, odd rows are addressed right-to-left.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
en  in  1  scheduler enable. Sampled only in IDLE.
req  in  2  frame request per source; bit0 = scroll, bit1 = overlay.
fg_colour  in  64  {src1, src0} 32-bit foreground colour words.
bg_colour  in  64  {src1, src0} 32-bit background colour words.
pix_addr  out  6  pixel index presented to the granted source.
pix_rd  out  1  one-cycle pixel read strobe.
pix_bit  in  2  per-source pixel bit. Valid 1 clk after pix_rd.
gnt  out  2  one-hot grant. Held for the entire frame.
frame_done  out  2  one-clk pulse to the served source at end of frame.
busy  out  1  high in all states except IDLE.
led_clk  out  1  strip clock.
led_data  out  1  strip data.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, rr pointer = src0 priority, tick counter 0, tick_pending 0.
- Tick counter: free-running 0..FRAME_DIV-1. On wrap it sets tick_pending.
  - tick_pending is a single flag. Extra ticks that arrive while it is already set are dropped.
  - tick_pending clears when a frame starts.
- Serial bit timing: each bit takes 2 clk.
  - Phase A: led_clk=0, led_data = new bit.
  - Phase B: led_clk=1, data unchanged.
  - Bits go out MSB first. led_clk is 0 in every non-shifting state.
- States:
  - IDLE: if en && tick_pending && |req, go to ARB. Otherwise stay.
  - ARB (1 clk): grant the requester after the rr pointer. If only one request is active, grant that one. Set gnt, load LED index n=0, move the rr pointer past the winner, then go to START.
  - START: 32 zero bits (64 clk), then go to FETCH.
  - FETCH (2 clk):
    - Cycle 1: pix_rd=1, pix_addr = map(n).
    - Cycle 2: capture pix_bit[granted] and load the shifter with that source's fg word if the bit is 1, else its bg word. Go to LED.
  - LED: shift 32 bits (64 clk). Then n=n+1. If n==NUM_LEDS go to END, else go to FETCH.
  - END: 64 zero bits (128 clk). Then pulse frame_done[granted] for 1 clk, clear gnt, go to IDLE.
- Address map: row = n/8, col = n%8. If SNAKE && row odd, pix_addr = row*8 + 7 - col; else pix_addr = n.
- Frame length: 1 (ARB) + 64 + NUM_LEDS*66 + 128 = 4417 clk at NUM_LEDS=64.
- Boundary rules:
  - Requests are sampled only in ARB. A requester that drops req mid-frame is still served to END.
  - Colour inputs are sampled at FETCH cycle 2 only. Changes take effect from the next LED.
  - en low mid-frame does not abort the frame. The frame completes, then the block holds IDLE.
  - Both requests active every frame: grants alternate src0, src1, src0, ...
  - A tick with no req leaves tick_pending set. A later req then starts a frame immediately.
  - Reset asserted mid-frame: led_clk and led_data go to 0 immediately and no frame_done pulse is issued. The next frame restarts with a full start frame.

Test Plan:
- Reset release, en=1, req=01, FRAME_DIV=5000 -> ARB at ~clk 5000. gnt=01 for 4417 clk. First 32 led_clk rising edges sample led_data=0. frame_done[0] pulses once.
- src0 pix_bit=1 only at addr 0; fg0=32'hf0000f00, bg0=32'hf0070000 -> LED word 0 = f0000f00, words 1..63 = f0070000, followed by 64 zero bits.
- SNAKE=1: pix_addr sequence for n=8..15 -> 15,14,...,8. n=16 -> 16.
- req=11 held for 4 frames -> gnt sequence 01,10,01,10; frame_done alternates to match.
- req[0] dropped at n=10 -> frame completes with all 64 LED words. frame_done[0]=1. Next frame does not start until req rises.
- reset asserted at n=30 then released -> outputs 0 during reset. The next frame begins with 32 zero bits and n=0. No stale frame_done.
